// File: rtl/pipe_pkg.sv
// Shared definitions for flow-controlled pipeline stage registers:
// occupancy state, ARM ID->EX control bit positions and default widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam int WB_EN_B    = 0;
  localparam int MEM_R_EN_B = 1;
  localparam int MEM_W_EN_B = 2;
  localparam int B_B        = 3;
  localparam int S_B        = 4;

  localparam int CTRL_W_ID_EX = 5;
  localparam int DATA_W_ID_EX = 141;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: load-enabled ctrl+data register whose ctrl field can be
// squashed synchronously while the data field keeps its value.
module pipe_entry #(
  parameter int unsigned CTRL_W = 5,
  parameter int unsigned DATA_W = 141
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  // NOTE: the wide data field is reset too, because out_data must read 0
  // straight out of reset; clear has priority over load and only touches ctrl.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_ctrl <= '0;
      q_data <= '0;
    end else if (clear) begin
      q_ctrl <= '0;
    end else if (load) begin
      q_ctrl <= d_ctrl;
      q_data <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer so
// that in_ready can come from a flop; flush squashes all control bits.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_ID_EX,
  parameter int unsigned DATA_W = DATA_W_ID_EX,
  parameter bit          SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  pipe_state_e       state, state_nxt;
  logic              in_fire, out_fire;
  logic              head_load, head_from_skid;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl, head_d_ctrl;
  logic [DATA_W-1:0] skid_data, head_d_data;

  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt      = state;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_fire) begin
          head_load = 1'b1;
          state_nxt = ONE;
        end
        ONE: begin
          if (in_fire && out_fire) begin
            head_load = 1'b1;
          end else if (in_fire) begin
            state_nxt = SKID ? TWO : ONE;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        TWO: if (out_fire) begin
          head_load      = 1'b1;
          head_from_skid = 1'b1;
          state_nxt      = ONE;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  assign head_d_ctrl = head_from_skid ? skid_ctrl : in_ctrl;
  assign head_d_data = head_from_skid ? skid_data : in_data;

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_head (
    .clk    (clk),
    .rst    (rst),
    .load   (head_load),
    .clear  (flush),
    .d_ctrl (head_d_ctrl),
    .d_data (head_d_data),
    .q_ctrl (head_ctrl),
    .q_data (out_data)
  );

  generate
    if (SKID) begin : g_skid
      logic skid_load;
      logic in_ready_q;

      // Overflow slot is written only when the head is busy and stalled.
      assign skid_load = (state == ONE) & in_fire & ~out_fire & ~flush;

      pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .clear  (flush),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .q_ctrl (skid_ctrl),
        .q_data (skid_data)
      );

      always_ff @(posedge clk or posedge rst) begin
        if (rst) in_ready_q <= 1'b1;
        else     in_ready_q <= (state_nxt != TWO);
      end
      assign in_ready = in_ready_q;
    end else begin : g_no_skid
      assign skid_ctrl = '0;
      assign skid_data = '0;
      assign in_ready  = ~out_valid | out_ready;
    end
  endgenerate

  // Bubbles never leak control bits downstream.
  assign out_ctrl  = out_valid ? head_ctrl : '0;
  assign occupancy = state;

endmodule
